// File: rtl/pc_sp_unit_pkg.sv
// Shared state/opcode codes and reset defaults for the address-side datapath.
// The control FSM and this block must agree on these encodings.
package pc_sp_unit_pkg;

  localparam logic [7:0] STATE_IDLE       = 8'h00;
  localparam logic [7:0] STATE_FETCH_PC   = 8'h01;
  localparam logic [7:0] STATE_FETCH_INST = 8'h02;
  localparam logic [7:0] STATE_FETCH_SP   = 8'h03;
  localparam logic [7:0] STATE_INC_SP     = 8'h04;
  localparam logic [7:0] STATE_STACK_REG  = 8'h05;
  localparam logic [7:0] STATE_SET_REG    = 8'h06;
  localparam logic [7:0] STATE_STORE_PC   = 8'h07;
  localparam logic [7:0] STATE_TMP_JUMP   = 8'h08;
  localparam logic [7:0] STATE_JUMP       = 8'h09;
  localparam logic [7:0] STATE_RET        = 8'h0A;
  localparam logic [7:0] STATE_LOAD_ADDR  = 8'h0B;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_JMP  = 8'h10;
  localparam logic [7:0] OP_CALL = 8'h20;
  localparam logic [7:0] OP_RET  = 8'h21;
  localparam logic [7:0] OP_PUSH = 8'h30;
  localparam logic [7:0] OP_POP  = 8'h31;

  localparam logic [7:0] PC_RESET_DEFAULT = 8'h00;
  localparam logic [7:0] SP_RESET_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    SP_HOLD = 2'd0,
    SP_INC  = 2'd1,
    SP_DEC  = 2'd2
  } sp_op_e;

endpackage

// File: rtl/pc_sp_unit_stack_ptr.sv
// Stack pointer register: empty-descending, wraps modulo 2^ADDR_W and raises a
// sticky error when a wrap occurs in either direction.
module pc_sp_unit_stack_ptr
  import pc_sp_unit_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]    SP_RESET = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  sp_op_e            sp_op,
  output logic [ADDR_W-1:0] sp,
  output logic              stack_err
);

  logic [ADDR_W-1:0] sp_q, sp_d;
  logic              err_q, err_d;

  always_comb begin
    sp_d  = sp_q;
    err_d = err_q;
    case (sp_op)
      SP_INC: begin
        sp_d = sp_q + ADDR_W'(1);
        if (sp_q == '1) err_d = 1'b1;
      end
      SP_DEC: begin
        sp_d = sp_q - ADDR_W'(1);
        if (sp_q == '0) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q  <= SP_RESET;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  assign sp        = sp_q;
  assign stack_err = err_q;

endmodule

// File: rtl/pc_sp_unit.sv
// Address-side datapath: PC, jump-target temp and MAR, plus the CALL stack write
// path. Every register update is keyed off the registered FSM state code.
module pc_sp_unit
  import pc_sp_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] PC_RESET = PC_RESET_DEFAULT,
  parameter logic [ADDR_W-1:0] SP_RESET = SP_RESET_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        state,
  input  logic [7:0]        opcode,
  input  logic              cond_ok,
  input  logic [7:0]        data_in,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data_out,
  output logic              mem_we,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] sp,
  output logic              stack_err
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tmp_q, tmp_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              mem_we_q, mem_we_d;
  sp_op_e            sp_op;

  pc_sp_unit_stack_ptr #(
    .ADDR_W   (ADDR_W),
    .SP_RESET (SP_RESET)
  ) u_stack_ptr (
    .clk       (clk),
    .reset     (reset),
    .sp_op     (sp_op),
    .sp        (sp),
    .stack_err (stack_err)
  );

  // Unknown state codes fall through to the defaults, so nothing moves.
  always_comb begin
    pc_d       = pc_q;
    tmp_d      = tmp_q;
    addr_d     = addr_q;
    data_out_d = data_out_q;
    mem_we_d   = 1'b0;
    sp_op      = SP_HOLD;
    case (state)
      STATE_FETCH_PC: begin
        addr_d = pc_q;
        pc_d   = pc_q + ADDR_W'(1);
      end
      STATE_FETCH_SP:  addr_d = sp;
      STATE_INC_SP:    sp_op  = SP_INC;
      STATE_STACK_REG: sp_op  = SP_DEC;
      STATE_SET_REG: begin
        if (opcode == OP_CALL) tmp_d = data_in;
      end
      STATE_STORE_PC: begin
        addr_d     = sp;
        data_out_d = pc_q;
        mem_we_d   = 1'b1;
        sp_op      = SP_DEC;
      end
      STATE_TMP_JUMP: pc_d = tmp_q;
      STATE_JUMP: begin
        if (cond_ok) pc_d = data_in;
      end
      STATE_RET:       pc_d   = data_in;
      STATE_LOAD_ADDR: addr_d = data_in;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= PC_RESET;
      tmp_q      <= '0;
      addr_q     <= '0;
      data_out_q <= '0;
      mem_we_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tmp_q      <= tmp_d;
      addr_q     <= addr_d;
      data_out_q <= data_out_d;
      mem_we_q   <= mem_we_d;
    end
  end

  assign pc       = pc_q;
  assign addr     = addr_q;
  assign data_out = data_out_q;
  assign mem_we   = mem_we_q;

endmodule

// File: tb/tb_pc_sp_unit.sv
// Bench for pc_sp_unit: directed vector table, hand-written wrap/reset sequences
// and a random run against an arithmetic reference model.
module tb_pc_sp_unit;
  import pc_sp_unit_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] state;
  logic [7:0] opcode;
  logic       cond_ok;
  logic [7:0] data_in;
  logic [7:0] addr;
  logic [7:0] data_out;
  logic       mem_we;
  logic [7:0] pc;
  logic [7:0] sp;
  logic       stack_err;

  int tests_run = 0;
  int tests_failed = 0;

  pc_sp_unit dut (
    .clk       (clk),
    .reset     (reset),
    .state     (state),
    .opcode    (opcode),
    .cond_ok   (cond_ok),
    .data_in   (data_in),
    .addr      (addr),
    .data_out  (data_out),
    .mem_we    (mem_we),
    .pc        (pc),
    .sp        (sp),
    .stack_err (stack_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected values for the scoreboard
  logic [7:0] exp_q[$];

  // reference model state (plain integers, mod 256)
  int m_pc, m_sp, m_tmp, m_addr, m_dout, m_we, m_err;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // one clock: inputs change at negedge, outputs sampled 1 time unit after posedge
  task automatic apply(input logic rst, input logic [7:0] st, input logic [7:0] op,
                       input logic c, input logic [7:0] d);
    @(negedge clk);
    reset   = rst;
    state   = st;
    opcode  = op;
    cond_ok = c;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = 0; m_sp = 255; m_tmp = 0; m_addr = 0; m_dout = 0; m_we = 0; m_err = 0;
  endtask

  task automatic model_step(input logic [7:0] st, input logic [7:0] op,
                            input logic c, input logic [7:0] d);
    m_we = 0;
    if (st == STATE_FETCH_PC) begin
      m_addr = m_pc;
      m_pc = (m_pc + 1) % 256;
    end else if (st == STATE_FETCH_SP) begin
      m_addr = m_sp;
    end else if (st == STATE_INC_SP) begin
      if (m_sp == 255) m_err = 1;
      m_sp = (m_sp + 1) % 256;
    end else if (st == STATE_STACK_REG) begin
      if (m_sp == 0) m_err = 1;
      m_sp = (m_sp + 255) % 256;
    end else if (st == STATE_SET_REG) begin
      if (op == OP_CALL) m_tmp = d;
    end else if (st == STATE_STORE_PC) begin
      m_addr = m_sp;
      m_dout = m_pc;
      m_we = 1;
      if (m_sp == 0) m_err = 1;
      m_sp = (m_sp + 255) % 256;
    end else if (st == STATE_TMP_JUMP) begin
      m_pc = m_tmp;
    end else if (st == STATE_JUMP) begin
      if (c) m_pc = d;
    end else if (st == STATE_RET) begin
      m_pc = d;
    end else if (st == STATE_LOAD_ADDR) begin
      m_addr = d;
    end
  endtask

  // drive one cycle, advance the model, and compare every output
  task automatic step_model(input logic [7:0] st, input logic [7:0] op,
                            input logic c, input logic [7:0] d, input string tag);
    apply(1'b0, st, op, c, d);
    model_step(st, op, c, d);
    exp_q.push_back(8'(m_pc));
    exp_q.push_back(8'(m_sp));
    exp_q.push_back(8'(m_addr));
    exp_q.push_back(8'(m_dout));
    exp_q.push_back(8'(m_we));
    exp_q.push_back(8'(m_err));
    check8({tag, " pc"},        pc,                 exp_q.pop_front());
    check8({tag, " sp"},        sp,                 exp_q.pop_front());
    check8({tag, " addr"},      addr,               exp_q.pop_front());
    check8({tag, " data_out"},  data_out,           exp_q.pop_front());
    check8({tag, " mem_we"},    {7'd0, mem_we},     exp_q.pop_front());
    check8({tag, " stack_err"}, {7'd0, stack_err},  exp_q.pop_front());
  endtask

  typedef struct {
    logic [7:0] st;
    logic [7:0] op;
    logic       c;
    logic [7:0] d;
    logic [7:0] e_pc;
    logic [7:0] e_sp;
    logic [7:0] e_addr;
    logic [7:0] e_dout;
    logic       e_we;
    logic       e_err;
  } vec_t;

  vec_t vecs[19];

  initial begin
    // st, op, cond, data_in -> pc, sp, addr, data_out, mem_we, stack_err
    vecs[0]  = '{STATE_FETCH_PC,   OP_NOP,  1'b0, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{STATE_FETCH_PC,   OP_NOP,  1'b0, 8'h00, 8'h02, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{STATE_FETCH_PC,   OP_NOP,  1'b0, 8'h00, 8'h03, 8'hFF, 8'h02, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{STATE_JUMP,       OP_JMP,  1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{STATE_FETCH_PC,   OP_NOP,  1'b0, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{STATE_JUMP,       OP_JMP,  1'b1, 8'h40, 8'h40, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{STATE_JUMP,       OP_JMP,  1'b0, 8'h55, 8'h40, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{STATE_JUMP,       OP_JMP,  1'b1, 8'h10, 8'h10, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{STATE_SET_REG,    OP_CALL, 1'b0, 8'h80, 8'h10, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{STATE_STORE_PC,   OP_CALL, 1'b0, 8'h00, 8'h10, 8'hFE, 8'hFF, 8'h10, 1'b1, 1'b0};
    vecs[10] = '{STATE_TMP_JUMP,   OP_CALL, 1'b0, 8'h00, 8'h80, 8'hFE, 8'hFF, 8'h10, 1'b0, 1'b0};
    vecs[11] = '{STATE_INC_SP,     OP_RET,  1'b0, 8'h00, 8'h80, 8'hFF, 8'hFF, 8'h10, 1'b0, 1'b0};
    vecs[12] = '{STATE_FETCH_SP,   OP_RET,  1'b0, 8'h00, 8'h80, 8'hFF, 8'hFF, 8'h10, 1'b0, 1'b0};
    vecs[13] = '{STATE_RET,        OP_RET,  1'b0, 8'h10, 8'h10, 8'hFF, 8'hFF, 8'h10, 1'b0, 1'b0};
    vecs[14] = '{STATE_SET_REG,    OP_JMP,  1'b0, 8'h33, 8'h10, 8'hFF, 8'hFF, 8'h10, 1'b0, 1'b0};
    vecs[15] = '{STATE_TMP_JUMP,   OP_JMP,  1'b0, 8'h00, 8'h80, 8'hFF, 8'hFF, 8'h10, 1'b0, 1'b0};
    vecs[16] = '{STATE_LOAD_ADDR,  OP_NOP,  1'b0, 8'hA5, 8'h80, 8'hFF, 8'hA5, 8'h10, 1'b0, 1'b0};
    vecs[17] = '{STATE_FETCH_INST, OP_NOP,  1'b1, 8'h77, 8'h80, 8'hFF, 8'hA5, 8'h10, 1'b0, 1'b0};
    vecs[18] = '{8'hEE,            OP_CALL, 1'b1, 8'h99, 8'h80, 8'hFF, 8'hA5, 8'h10, 1'b0, 1'b0};
  end

  initial begin
    logic [7:0] rand_states[14];
    rand_states = '{STATE_IDLE, STATE_FETCH_PC, STATE_FETCH_INST, STATE_FETCH_SP,
                    STATE_INC_SP, STATE_STACK_REG, STATE_SET_REG, STATE_STORE_PC,
                    STATE_TMP_JUMP, STATE_JUMP, STATE_RET, STATE_LOAD_ADDR,
                    8'h5C, 8'hFF};

    reset = 1'b1; state = STATE_IDLE; opcode = OP_NOP; cond_ok = 1'b0; data_in = 8'h00;

    // reset state
    apply(1'b1, STATE_IDLE, OP_NOP, 1'b0, 8'h00);
    apply(1'b1, STATE_IDLE, OP_NOP, 1'b0, 8'h00);
    check8("rst pc",        pc,                8'h00);
    check8("rst sp",        sp,                8'hFF);
    check8("rst addr",      addr,              8'h00);
    check8("rst data_out",  data_out,          8'h00);
    check8("rst mem_we",    {7'd0, mem_we},    8'h00);
    check8("rst stack_err", {7'd0, stack_err}, 8'h00);

    // directed vector table: fetch, pc wrap, jumps, CALL and RET paths
    foreach (vecs[i]) begin
      apply(1'b0, vecs[i].st, vecs[i].op, vecs[i].c, vecs[i].d);
      check8($sformatf("vec%0d pc", i),        pc,                vecs[i].e_pc);
      check8($sformatf("vec%0d sp", i),        sp,                vecs[i].e_sp);
      check8($sformatf("vec%0d addr", i),      addr,              vecs[i].e_addr);
      check8($sformatf("vec%0d data_out", i),  data_out,          vecs[i].e_dout);
      check8($sformatf("vec%0d mem_we", i),    {7'd0, mem_we},    {7'd0, vecs[i].e_we});
      check8($sformatf("vec%0d stack_err", i), {7'd0, stack_err}, {7'd0, vecs[i].e_err});
    end

    // stack overflow at sp=00: wraps to FF, error sticks through later ops
    apply(1'b1, STATE_IDLE, OP_NOP, 1'b0, 8'h00);
    model_reset();
    for (int i = 0; i < 255; i++) step_model(STATE_STACK_REG, OP_PUSH, 1'b0, 8'h00, "push");
    check8("sp at bottom", sp, 8'h00);
    check8("no err before wrap", {7'd0, stack_err}, 8'h00);
    step_model(STATE_STACK_REG, OP_PUSH, 1'b0, 8'h00, "ovf");
    check8("ovf sp", sp, 8'hFF);
    check8("ovf err", {7'd0, stack_err}, 8'h01);
    step_model(STATE_INC_SP, OP_POP, 1'b0, 8'h00, "udf");
    step_model(STATE_FETCH_PC, OP_NOP, 1'b0, 8'h00, "after err");
    step_model(STATE_RET, OP_RET, 1'b0, 8'h42, "after err");
    check8("err sticky", {7'd0, stack_err}, 8'h01);

    // reset coinciding with STORE_PC: no write strobe, everything back to reset values
    apply(1'b1, STATE_IDLE, OP_NOP, 1'b0, 8'h00);
    apply(1'b0, STATE_FETCH_PC, OP_NOP, 1'b0, 8'h00);
    apply(1'b0, STATE_FETCH_PC, OP_NOP, 1'b0, 8'h00);
    apply(1'b1, STATE_STORE_PC, OP_CALL, 1'b0, 8'h00);
    check8("rst@store mem_we",    {7'd0, mem_we},    8'h00);
    check8("rst@store pc",        pc,                8'h00);
    check8("rst@store sp",        sp,                8'hFF);
    check8("rst@store addr",      addr,              8'h00);
    check8("rst@store data_out",  data_out,          8'h00);
    check8("rst@store stack_err", {7'd0, stack_err}, 8'h00);
    apply(1'b0, STATE_IDLE, OP_NOP, 1'b0, 8'h00);
    check8("rst@store mem_we later", {7'd0, mem_we}, 8'h00);

    // random run against the model, with occasional resets
    apply(1'b1, STATE_IDLE, OP_NOP, 1'b0, 8'h00);
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] st, op, d;
      logic c;
      if ($urandom_range(0, 199) == 0) begin
        apply(1'b1, rand_states[$urandom_range(0, 13)], OP_CALL, 1'b1, 8'(8'($urandom)));
        model_reset();
      end else begin
        st = rand_states[$urandom_range(0, 13)];
        op = ($urandom_range(0, 1) == 1) ? OP_CALL : 8'($urandom);
        c  = 1'($urandom_range(0, 1));
        d  = 8'($urandom);
        step_model(st, op, c, d, "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
